// File: rtl/bcd_display_driver.sv
// bcd_display_driver
// Binary (0..9999) to 4-digit BCD converter using a bit-serial restoring
// divide-by-10, plus a multiplexed common-anode 7-segment display driver.
//
// state | meaning
// IDLE  | waiting for load; display shows latched digits
// DIV   | one restoring-division step per cycle, 14 steps per digit
// STORE | write remainder into digit slot idx, start next pass or finish
// DONE  | publish digits/overflow, pulse done, return to IDLE
module bcd_display_driver #(
    parameter int SCAN_DIV       = 16,
    parameter int BLANK_LEADING  = 1,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [13:0] value,
    output logic        busy,
    output logic        done,
    output logic        overflow,
    output logic [15:0] digits,
    output logic [3:0]  an,
    output logic [6:0]  seg
);

    localparam int SCW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic [1:0] {IDLE, DIV, STORE, DONE} state_t;

    state_t      state, state_nx;
    logic [13:0] work, work_nx;
    logic [3:0]  rem, rem_nx;
    logic [3:0]  bitcnt, bitcnt_nx;
    logic [1:0]  idx, idx_nx;
    logic        ovf, ovf_nx;
    logic [15:0] temp, temp_nx;
    logic [15:0] digits_nx;
    logic        overflow_nx;
    logic        done_nx;
    logic [4:0]  t;

    logic [SCW-1:0] scan_cnt;
    logic [1:0]     sel;
    logic [3:0]     cur;
    logic           blank;
    logic [6:0]     pat;

    // Converter state and datapath registers; reset aborts any conversion.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            work     <= '0;
            rem      <= '0;
            bitcnt   <= '0;
            idx      <= '0;
            ovf      <= 1'b0;
            temp     <= '0;
            digits   <= '0;
            overflow <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nx;
            work     <= work_nx;
            rem      <= rem_nx;
            bitcnt   <= bitcnt_nx;
            idx      <= idx_nx;
            ovf      <= ovf_nx;
            temp     <= temp_nx;
            digits   <= digits_nx;
            overflow <= overflow_nx;
            done     <= done_nx;
        end
    end

    assign t = {rem, work[13]};

    // Next-state and datapath updates for the divide/store sequence.
    always_comb begin
        state_nx    = state;
        work_nx     = work;
        rem_nx      = rem;
        bitcnt_nx   = bitcnt;
        idx_nx      = idx;
        ovf_nx      = ovf;
        temp_nx     = temp;
        digits_nx   = digits;
        overflow_nx = overflow;
        done_nx     = 1'b0;
        case (state)
            IDLE: begin
                // A load coinciding with the done pulse is dropped.
                if (load && !done) begin
                    work_nx   = value;
                    rem_nx    = '0;
                    bitcnt_nx = 4'd13;
                    idx_nx    = '0;
                    ovf_nx    = (value > 14'd9999);
                    state_nx  = (value > 14'd9999) ? DONE : DIV;
                end
            end
            DIV: begin
                // t is at most 19, so the 4-bit wraparound subtract is exact.
                if (t >= 5'd10) begin
                    rem_nx  = t[3:0] - 4'd10;
                    work_nx = {work[12:0], 1'b1};
                end else begin
                    rem_nx  = t[3:0];
                    work_nx = {work[12:0], 1'b0};
                end
                if (bitcnt == 4'd0) begin
                    state_nx = STORE;
                end else begin
                    bitcnt_nx = bitcnt - 4'd1;
                end
            end
            STORE: begin
                case (idx)
                    2'd0:    temp_nx[3:0]   = rem;
                    2'd1:    temp_nx[7:4]   = rem;
                    2'd2:    temp_nx[11:8]  = rem;
                    default: temp_nx[15:12] = rem;
                endcase
                rem_nx    = '0;
                bitcnt_nx = 4'd13;
                if (idx == 2'd3) begin
                    state_nx = DONE;
                end else begin
                    idx_nx   = idx + 2'd1;
                    state_nx = DIV;
                end
            end
            DONE: begin
                if (!ovf) begin
                    digits_nx = temp;
                end
                overflow_nx = ovf;
                done_nx     = 1'b1;
                state_nx    = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // Scan timer: each digit stays lit for SCAN_DIV clocks, then select advances.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scan_cnt <= '0;
            sel      <= '0;
        end else if (scan_cnt == SCW'(SCAN_DIV - 1)) begin
            scan_cnt <= '0;
            sel      <= sel + 2'd1;
        end else begin
            scan_cnt <= scan_cnt + SCW'(1);
        end
    end

    // Pick the selected digit from the latched result and apply leading-zero blanking.
    always_comb begin
        cur   = digits[3:0];
        blank = 1'b0;
        case (sel)
            2'd0: cur = digits[3:0];
            2'd1: begin
                cur   = digits[7:4];
                blank = (BLANK_LEADING != 0) && (digits[15:4] == 12'd0);
            end
            2'd2: begin
                cur   = digits[11:8];
                blank = (BLANK_LEADING != 0) && (digits[15:8] == 8'd0);
            end
            default: begin
                cur   = digits[15:12];
                blank = (BLANK_LEADING != 0) && (digits[15:12] == 4'd0);
            end
        endcase
    end

    // Segment decode (active-high a..g), overflow dash, then output polarity.
    always_comb begin
        pat = 7'b0000000;
        if (overflow) begin
            pat = 7'b0000001;
        end else if (!blank) begin
            case (cur)
                4'd0:    pat = 7'b1111110;
                4'd1:    pat = 7'b0110000;
                4'd2:    pat = 7'b1101101;
                4'd3:    pat = 7'b1111001;
                4'd4:    pat = 7'b0110011;
                4'd5:    pat = 7'b1011011;
                4'd6:    pat = 7'b1011111;
                4'd7:    pat = 7'b1110000;
                4'd8:    pat = 7'b1111111;
                4'd9:    pat = 7'b1111011;
                default: pat = 7'b0000000;
            endcase
        end
        seg = (SEG_ACTIVE_LOW != 0) ? ~pat : pat;
        an  = ~(4'b0001 << sel);
    end

endmodule

// File: tb/tb_bcd_display_driver.sv
// Scoreboard bench for bcd_display_driver: stimulus pushes expected results,
// a monitor compares them against each done pulse.
module tb_bcd_display_driver;

    localparam int SD = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        load = 1'b0;
    logic [13:0] value = '0;
    logic        busy, done, overflow;
    logic [15:0] digits;
    logic [3:0]  an;
    logic [6:0]  seg;

    bcd_display_driver #(.SCAN_DIV(SD), .BLANK_LEADING(1), .SEG_ACTIVE_LOW(1)) dut (
        .clk(clk), .rst(rst), .load(load), .value(value), .busy(busy), .done(done),
        .overflow(overflow), .digits(digits), .an(an), .seg(seg)
    );

    always #5 clk = ~clk;

    int gcyc = 0;
    always @(posedge clk) gcyc <= gcyc + 1;

    int scyc;
    always @(posedge clk or negedge rst) begin
        if (!rst) scyc <= 0;
        else      scyc <= scyc + 1;
    end

    typedef struct {
        logic [15:0] d;
        logic        o;
        int          at;
    } exp_t;
    exp_t sbq[$];
    exp_t e;

    int checks = 0;
    int passed = 0;

    int  model_val = 0;
    logic model_ovf = 1'b0;

    localparam logic [6:0] TBL[10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                                       7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                                       7'b1111111, 7'b1111011};
    localparam int POW[4] = '{1, 10, 100, 1000};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [6:0] exp_seg(input int v, input logic o, input int s);
        logic [6:0] p;
        if (o) p = 7'b0000001;
        else if (s > 0 && v < POW[s]) p = 7'b0000000;
        else p = TBL[(v / POW[s]) % 10];
        return ~p;
    endfunction

    logic prev_done = 1'b0;
    always @(negedge clk) begin
        if (rst && done) begin
            chk("done_width", {31'd0, prev_done}, 32'd0);
            if (sbq.size() == 0) begin
                chk("spurious_done", 32'd1, 32'd0);
            end else begin
                e = sbq.pop_front();
                chk("digits", {16'd0, digits}, {16'd0, e.d});
                chk("overflow", {31'd0, overflow}, {31'd0, e.o});
                chk("done_cycle", gcyc, e.at);
            end
        end
        prev_done = rst && done;
    end

    task automatic wait_idle();
        int n = 0;
        while ((busy || done) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) chk("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic issue(input int v);
        exp_t x;
        logic o;
        wait_idle();
        @(negedge clk);
        load  = 1'b1;
        value = 14'(v);
        @(posedge clk);
        #1;
        o    = (v > 9999);
        x.o  = o;
        x.d  = o ? to_bcd(model_val) : to_bcd(v);
        x.at = gcyc + (o ? 1 : 61);
        sbq.push_back(x);
        if (!o) model_val = v;
        model_ovf = o;
        @(negedge clk);
        load = 1'b0;
        chk("busy_after_load", {31'd0, busy}, 32'd1);
    endtask

    task automatic sweep();
        int s;
        wait_idle();
        repeat (4 * SD) begin
            @(negedge clk);
            s = (scyc / SD) % 4;
            chk("an", {28'd0, an}, {28'd0, ~(4'b0001 << s)});
            chk("seg", {25'd0, seg}, {25'd0, exp_seg(model_val, model_ovf, s)});
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        exp_t x;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        chk("rst_digits", {16'd0, digits}, 32'd0);
        chk("rst_an", {28'd0, an}, 32'hE);
        chk("rst_seg", {25'd0, seg}, 32'h01);
        @(negedge clk);
        rst = 1'b1;

        issue(1234);  sweep();
        issue(9999);
        issue(0);     sweep();
        issue(10000); sweep();
        issue(42);    sweep();

        // load held high while value changes mid-conversion
        wait_idle();
        @(negedge clk);
        load  = 1'b1;
        value = 14'd500;
        @(posedge clk);
        #1;
        x.d = to_bcd(500); x.o = 1'b0; x.at = gcyc + 61;
        sbq.push_back(x);
        model_val = 500; model_ovf = 1'b0;
        repeat (10) @(negedge clk);
        value = 14'd77;
        n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("hold_timeout", 32'd1, 32'd0);
        load = 1'b0;
        @(negedge clk);
        chk("hold_no_restart", {31'd0, busy}, 32'd0);
        sweep();

        // reset in the middle of a conversion
        issue(8765);
        repeat (29) @(negedge clk);
        rst = 1'b0;
        #1;
        sbq.delete();
        model_val = 0; model_ovf = 1'b0;
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_done", {31'd0, done}, 32'd0);
        chk("mid_rst_digits", {16'd0, digits}, 32'd0);
        chk("mid_rst_overflow", {31'd0, overflow}, 32'd0);
        chk("mid_rst_an", {28'd0, an}, 32'hE);
        chk("mid_rst_seg", {25'd0, seg}, 32'h01);
        @(negedge clk);
        rst = 1'b1;
        issue(8765);  sweep();

        for (int i = 0; i < 12; i++) begin
            if (i % 4 == 3) issue(int'($urandom_range(10000, 16383)));
            else            issue(int'($urandom_range(0, 9999)));
        end
        sweep();
        wait_idle();
        repeat (2) @(negedge clk);
        chk("scoreboard_empty", sbq.size(), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
